// File: rtl/pq_pkg.sv
// Shared widths, command-word layout and FSM encoding for the priority-queue command issuer.
// The command word is {valid, push, key, payload}; the request word drops the valid bit.
package pq_pkg;

  localparam int KEY_W         = 31;
  localparam int PAY_W         = 32;
  localparam int CMD_W         = 65;
  localparam int CMD_VALID_BIT = 64;
  localparam int CMD_PUSH_BIT  = 63;

  typedef struct packed {
    logic             valid;
    logic             push;
    logic [KEY_W-1:0] key;
    logic [PAY_W-1:0] payload;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pq_req_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head data is valid whenever empty is low.
// Latency: write visible at the head one cycle later. Backpressure: a write while full lands only if a read frees the slot.
module pq_req_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = mem[rd_ptr];
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pq_cmd_issuer.sv
// Buffers push/pop requests, checks them against queue occupancy and issues spaced 65-bit commands.
// Latency: 2 cycles from acceptance into an idle empty FIFO to cmd_o. Backpressure: req_ready = !fifo_full.
// Optional PQ_ISSUE_STATS_EN adds saturating push/pop/reject counters.
module pq_cmd_issuer #(
  parameter int KEY_W      = 31,
  parameter int PAY_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PQ_CAP     = 16,
  parameter int ISSUE_GAP  = 2
) (
  input  logic                         system1000,
  input  logic                         system1000_rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_push,
  input  logic [KEY_W-1:0]             req_key,
  input  logic [PAY_W-1:0]             req_payload,
  output logic [pq_pkg::CMD_W-1:0]     cmd_o,
  output logic [$clog2(PQ_CAP+1)-1:0]  occupancy,
  output logic                         rej_pulse,
  output logic                         busy
`ifdef PQ_ISSUE_STATS_EN
  ,
  output logic [15:0]                  push_cnt,
  output logic [15:0]                  pop_cnt,
  output logic [15:0]                  rej_cnt
`endif
);

  localparam int OCC_W = $clog2(PQ_CAP+1);
  localparam int GAP_W = $clog2(ISSUE_GAP+1);
  localparam int REQ_W = KEY_W + PAY_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  pq_pkg::state_t state;
  pq_pkg::state_t state_nxt;
  pq_pkg::cmd_t   cmd_nxt;

  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [REQ_W-1:0] head;
  logic [GAP_W-1:0] gap_cnt;
  logic             head_push;
  logic             legal;

  assign req_ready = !fifo_full;
  assign fifo_wr   = req_valid && req_ready;
  assign busy      = !fifo_empty || (gap_cnt != '0);

  pq_req_fifo #(
    .W     (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk    (system1000),
    .rst    (system1000_rst),
    .wr_en  (fifo_wr),
    .wr_dat ({req_push, req_key, req_payload}),
    .rd_en  (fifo_rd),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    head_push = head[REQ_W-1];
    legal     = head_push ? (occupancy != OCC_W'(PQ_CAP)) : (occupancy != '0);
    cmd_nxt         = '0;
    cmd_nxt.valid   = 1'b1;
    cmd_nxt.push    = head_push;
    // Pops carry no key/payload; zero them so the path stage sees a clean word.
    if (head_push) begin
      cmd_nxt.key     = head[PAY_W +: KEY_W];
      cmd_nxt.payload = head[PAY_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      pq_pkg::ST_IDLE: begin
        if (!fifo_empty) state_nxt = pq_pkg::ST_ISSUE;
      end
      pq_pkg::ST_ISSUE: begin
        fifo_rd = 1'b1;
        if (ISSUE_GAP > 1) begin
          state_nxt = pq_pkg::ST_GAP;
        end else if ((fifo_count > CNT_W'(1)) || fifo_wr) begin
          state_nxt = pq_pkg::ST_ISSUE;
        end else begin
          state_nxt = pq_pkg::ST_IDLE;
        end
      end
      pq_pkg::ST_GAP: begin
        // Leaving on the last gap cycle keeps issue spacing exactly ISSUE_GAP.
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = fifo_empty ? pq_pkg::ST_IDLE : pq_pkg::ST_ISSUE;
        end
      end
      default: state_nxt = pq_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state     <= pq_pkg::ST_IDLE;
      gap_cnt   <= '0;
      cmd_o     <= '0;
      occupancy <= '0;
      rej_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_o     <= '0;
      rej_pulse <= 1'b0;
      if (state == pq_pkg::ST_ISSUE) begin
        gap_cnt <= GAP_W'(ISSUE_GAP - 1);
        if (legal) begin
          cmd_o     <= cmd_nxt;
          occupancy <= head_push ? (occupancy + OCC_W'(1)) : (occupancy - OCC_W'(1));
        end else begin
          rej_pulse <= 1'b1;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

`ifdef PQ_ISSUE_STATS_EN
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
      rej_cnt  <= '0;
    end else if (state == pq_pkg::ST_ISSUE) begin
      if (!legal) begin
        if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
      end else if (head_push) begin
        if (push_cnt != 16'hFFFF) push_cnt <= push_cnt + 16'd1;
      end else begin
        if (pop_cnt != 16'hFFFF) pop_cnt <= pop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
